// File: rtl/race_phase_controller.sv
// race_phase_controller: menu/countdown/race/win sequencer that latches the first finisher.
module race_phase_controller #(
  parameter int MAX_POS         = 109,
  parameter int TICK_CYCLES     = 50000000,
  parameter int COUNTDOWN_STEPS = 3,
  parameter int WIN_HOLD_STEPS  = 5,
  localparam int PW = $clog2(MAX_POS),
  localparam int CW = $clog2(COUNTDOWN_STEPS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_btn,
  input  logic [PW-1:0] green_cur_pos,
  input  logic [PW-1:0] red_cur_pos,
  input  logic [PW-1:0] blue_cur_pos,
  input  logic [PW-1:0] yellow_cur_pos,
  output logic          is_in_menu,
  output logic          race_active,
  output logic [CW-1:0] countdown,
  output logic          pos_clear,
  output logic          winner_valid,
  output logic [1:0]    winner_id
);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = WIN_HOLD_STEPS > 1 ? $clog2(WIN_HOLD_STEPS) : 1;
  localparam logic [PW-1:0] FINISH = PW'(MAX_POS - 1);
  typedef enum logic [1:0] {MENU, COUNTDOWN, RACE, WIN} state_t;
  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [SW-1:0] step_q;
  logic          menu_q, active_q, clr_q, wv_q;
  logic [CW-1:0] cd_q;
  logic [1:0]    wid_q, win_id;
  logic [3:0]    fin;
  logic          tick_done;
  assign fin = {yellow_cur_pos == FINISH, blue_cur_pos == FINISH,
                red_cur_pos == FINISH, green_cur_pos == FINISH};
  assign tick_done = tick_q == TW'(TICK_CYCLES - 1);
  // green has the highest priority on a simultaneous finish
  always_comb win_id = fin[0] ? 2'd0 : fin[1] ? 2'd1 : fin[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MENU;
      tick_q   <= '0;
      step_q   <= '0;
      menu_q   <= 1'b1;
      active_q <= 1'b0;
      cd_q     <= '0;
      clr_q    <= 1'b0;
      wv_q     <= 1'b0;
      wid_q    <= '0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        MENU: if (start_btn) begin
          state_q <= COUNTDOWN;
          menu_q  <= 1'b0;
          cd_q    <= CW'(COUNTDOWN_STEPS);
          clr_q   <= 1'b1;
          tick_q  <= '0;
        end
        COUNTDOWN: begin
          tick_q <= tick_done ? '0 : tick_q + TW'(1);
          if (tick_done) begin
            cd_q <= cd_q - CW'(1);
            if (cd_q == CW'(1)) begin
              state_q  <= RACE;
              active_q <= 1'b1;
            end
          end
        end
        RACE: if (|fin) begin
          state_q  <= WIN;
          active_q <= 1'b0;
          wv_q     <= 1'b1;
          wid_q    <= win_id;
          tick_q   <= '0;
          step_q   <= '0;
        end
        WIN: begin
          tick_q <= tick_done ? '0 : tick_q + TW'(1);
          if (tick_done) step_q <= step_q + SW'(1);
          // a start press only cuts the hold short; a fresh press is needed to race again
          if (start_btn || (tick_done && step_q == SW'(WIN_HOLD_STEPS - 1))) begin
            state_q <= MENU;
            menu_q  <= 1'b1;
            wv_q    <= 1'b0;
            wid_q   <= '0;
          end
        end
        default: state_q <= MENU;
      endcase
    end
  end
  assign is_in_menu   = menu_q;
  assign race_active  = active_q;
  assign countdown    = cd_q;
  assign pos_clear    = clr_q;
  assign winner_valid = wv_q;
  assign winner_id    = wid_q;
endmodule

// File: tb/tb_race_phase_controller.sv
// tb_race_phase_controller: scenario tasks with a queue of hand-derived per-cycle expected outputs.
module tb_race_phase_controller;
  localparam int MAX_POS = 109, TICK = 4, CDS = 3, WHS = 2;
  logic       clk = 1'b0, reset = 1'b1, start_btn = 1'b0;
  logic [6:0] g = '0, r = '0, b = '0, y = '0;
  logic       is_in_menu, race_active, pos_clear, winner_valid;
  logic [1:0] countdown, winner_id;
  logic [7:0] obs, exp_v;
  logic [7:0] sb[$];
  int checks = 0, failures = 0;
  race_phase_controller #(.MAX_POS(MAX_POS), .TICK_CYCLES(TICK), .COUNTDOWN_STEPS(CDS),
                          .WIN_HOLD_STEPS(WHS)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .green_cur_pos(g), .red_cur_pos(r), .blue_cur_pos(b), .yellow_cur_pos(y),
    .is_in_menu(is_in_menu), .race_active(race_active), .countdown(countdown),
    .pos_clear(pos_clear), .winner_valid(winner_valid), .winner_id(winner_id));
  always #5 clk = ~clk;
  assign obs = {is_in_menu, race_active, countdown, pos_clear, winner_valid, winner_id};
  function automatic logic [7:0] o(input logic m, input logic a, input logic [1:0] cd,
                                   input logic c, input logic w, input logic [1:0] id);
    return {m, a, cd, c, w, id};
  endfunction
  task automatic test_reset();
    for (int i = 0; i < 12; i++) sb.push_back(o(1, 0, 0, 0, 0, 0));
    g = 7'd108; r = 7'd108; b = 7'd108; y = 7'd108;
    for (int i = 0; i < 12; i++) begin
      reset = i < 2;
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset[%0d] got=%b expected=%b", i, obs, exp_v);
      end
    end
    g = '0; r = '0; b = '0; y = '0;
  endtask
  task automatic test_countdown(input string tag, input int press);
    for (int i = 0; i < 12; i++) sb.push_back(o(0, 0, 2'(3 - i / 4), i == 0, 0, 0));
    sb.push_back(o(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 13; i++) begin
      start_btn = (i == 0) || (i == press);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b expected=%b", tag, i, obs, exp_v);
      end
    end
    start_btn = 1'b0;
  endtask
  task automatic test_race_winner();
    sb.push_back(o(0, 1, 0, 0, 0, 0));
    sb.push_back(o(0, 1, 0, 0, 0, 0));
    for (int i = 2; i < 6; i++) sb.push_back(o(0, 0, 0, 0, 1, 1));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      g = (i >= 3) ? 7'd108 : 7'd127;
      r = (i >= 2) ? 7'd108 : 7'd0;
      start_btn = (i == 1) || (i == 6);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL race_winner[%0d] got=%b expected=%b", i, obs, exp_v);
      end
    end
    start_btn = 1'b0; g = '0; r = '0;
  endtask
  task automatic test_simultaneous();
    sb.push_back(o(0, 1, 0, 0, 0, 0));
    for (int i = 1; i < 9; i++) sb.push_back(o(0, 0, 0, 0, 1, 2));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      b = (i >= 1) ? 7'd108 : 7'd0;
      y = b;
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL simultaneous[%0d] got=%b expected=%b", i, obs, exp_v);
      end
    end
    b = '0; y = '0;
  endtask
  task automatic test_early_finish();
    sb.push_back(o(0, 0, 0, 0, 1, 3));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      reset = i == 1;
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL early_finish[%0d] got=%b expected=%b", i, obs, exp_v);
      end
    end
    reset = 1'b0; y = '0;
  endtask
  task automatic test_reset_mid();
    sb.push_back(o(0, 0, 3, 1, 0, 0));
    for (int i = 1; i < 4; i++) sb.push_back(o(0, 0, 3, 0, 0, 0));
    sb.push_back(o(0, 0, 2, 0, 0, 0));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    sb.push_back(o(0, 0, 3, 1, 0, 0));
    sb.push_back(o(0, 0, 3, 0, 0, 0));
    sb.push_back(o(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      start_btn = (i == 0) || (i == 7);
      reset = (i == 5) || (i == 9);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid[%0d] got=%b expected=%b", i, obs, exp_v);
      end
    end
    start_btn = 1'b0; reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_countdown("countdown", -1);
    test_race_winner();
    test_countdown("countdown_ignore", 6);
    test_simultaneous();
    y = 7'd108;
    test_countdown("countdown_preset", -1);
    test_early_finish();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/race_phase_controller.md
Name: race_phase_controller

Overview:
Top-level game sequencer for the LED racer. It steps the game through four phases: menu, start countdown, race, and winner display. While the race runs, it watches the four player positions, and it latches the first player to reach the last LED as the winner. Its outputs gate player input (race_active), drive the strip renderer (is_in_menu, countdown, winner_id), and clear the position counters at race start (pos_clear).

Parameters:
MAX_POS, 109, number of LEDs on the track; finish position is MAX_POS-1
TICK_CYCLES, 50000000, clk cycles per countdown/display step (1 s at 50 MHz)
COUNTDOWN_STEPS, 3, number of countdown steps before the race starts (min 1)
WIN_HOLD_STEPS, 5, steps the winner display is held before returning to the menu (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
start_btn  input  1  debounced single-cycle start pulse
green_cur_pos  input  $clog2(MAX_POS)  green player position
red_cur_pos  input  $clog2(MAX_POS)  red player position
blue_cur_pos  input  $clog2(MAX_POS)  blue player position
yellow_cur_pos  input  $clog2(MAX_POS)  yellow player position
is_in_menu  output  1  high only in MENU
race_active  output  1  high only in RACE; enables player movement
countdown  output  $clog2(COUNTDOWN_STEPS+1)  remaining countdown steps, 0 outside COUNTDOWN
pos_clear  output  1  one-cycle pulse telling the position counters to return to 0
winner_valid  output  1  high only in WIN
winner_id  output  2  0=green, 1=red, 2=blue, 3=yellow; valid while winner_valid

Behaviour:
- One clock (clk). Synchronous active-high reset. All outputs are registered and change on the clk edge after the triggering input is sampled.
- Reset values: state=MENU, is_in_menu=1, race_active=0, countdown=0, pos_clear=0, winner_valid=0, winner_id=0. The tick and step counters also reset to 0.
- Reset asserted in any state returns the block to MENU on the next edge. Reset takes priority over every other input.
- States: MENU, COUNTDOWN, RACE, WIN.
- MENU:
  - start_btn=1 -> COUNTDOWN.
  - On the same edge: pos_clear=1 for exactly one cycle, countdown=COUNTDOWN_STEPS, is_in_menu=0, tick counter=0.
- COUNTDOWN:
  - Tick counter counts 0..TICK_CYCLES-1 and wraps to 0.
  - At each terminal count, countdown decrements.
  - When the terminal count occurs with countdown==1: -> RACE, countdown=0, race_active=1.
  - COUNTDOWN therefore lasts exactly COUNTDOWN_STEPS*TICK_CYCLES cycles.
  - start_btn is ignored.
- RACE:
  - Each cycle, each position is compared for equality with MAX_POS-1. Values >= MAX_POS are not finish.
  - On any match -> WIN, with race_active=0, winner_valid=1, and winner_id from a priority encode (green > red > blue > yellow on a simultaneous finish).
  - Winner is latched; later position changes do not alter it.
  - start_btn is ignored.
  - If a position already equals MAX_POS-1 on the first RACE cycle, the block enters WIN on the next edge.
- WIN:
  - Hold counter counts to WIN_HOLD_STEPS*TICK_CYCLES-1, then -> MENU: winner_valid=0, winner_id=0, is_in_menu=1.
  - start_btn=1 in WIN skips the remaining hold and goes to MENU immediately, but does not also start a countdown. A second start pulse is required.
- Output invariants:
  - Exactly one of is_in_menu, countdown!=0, race_active, winner_valid is high in any cycle.
  - pos_clear is high only on the first COUNTDOWN cycle.
- Counter widths come from $clog2 of their maximum values. No counter may overflow for the default parameters.

Test Plan:
Bench parameters: TICK_CYCLES=4, COUNTDOWN_STEPS=3, WIN_HOLD_STEPS=2, MAX_POS=109.
1. Reset for 2 cycles, then idle 10 cycles -> is_in_menu=1, all other outputs 0. Positions at 108 in MENU produce no state change.
2. start_btn pulse in MENU -> next cycle pos_clear=1 (one cycle), countdown=3. countdown reads 3, 2, 1 for 4 cycles each. race_active=1 exactly 12 cycles after the start edge.
3. In RACE, red_cur_pos steps to 108 -> next cycle winner_valid=1, winner_id=1, race_active=0. Then moving green to 108 leaves winner_id=1.
4. In RACE, blue and yellow both reach 108 in the same cycle -> winner_id=2. winner_valid stays high 8 cycles, then is_in_menu=1 and winner_id=0.
5. start_btn in WIN -> MENU next cycle, no pos_clear. start_btn in COUNTDOWN or RACE -> no effect on state or countdown.
6. Assert reset for one cycle mid-COUNTDOWN (countdown=2) and again mid-WIN -> next cycle all outputs are at their reset values and state is MENU.
